// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave: transfer/response encodings,
// size constants, slave FSM states and the byte-lane mask helper.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR1,
    ERR2
  } slvState_e;

  // Lanes covered by a transfer; low address bits below the size are ignored,
  // so a misaligned request lands on its naturally aligned container.
  function automatic logic [7:0] laneMask(input logic [2:0] hsize, input logic [2:0] addrLow);
    logic [3:0]  nBytes;
    logic [2:0]  base;
    logic [15:0] ones;
    nBytes   = 4'd1 << hsize;
    base     = addrLow & ~3'(nBytes - 4'd1);
    ones     = (16'd1 << nBytes) - 16'd1;
    laneMask = 8'(ones << base);
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite slave-side bus bundle; the master modport drives the address and
// write data, the slave modport returns read data, ready and response.
interface ahb_lite_sram_slave_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic                  HREADY;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahbl_sram_core.sv
// DEPTH x DATA_WIDTH storage with a byte-enable write port and a registered
// read port; the array itself is never reset.
module ahbl_sram_core #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  localparam int BPW        = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      wrIdx_i,
  input  logic [BPW-1:0]        wrMask_i,
  input  logic [DATA_WIDTH-1:0] wrData_i,
  input  logic                  rdEn_i,
  input  logic [IDX_W-1:0]      rdIdx_i,
  output logic [DATA_WIDTH-1:0] rdData_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdData_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int b = 0; b < BPW; b++) begin
        if (wrMask_i[b]) mem_q[wrIdx_i][8*b +: 8] <= wrData_i[8*b +: 8];
      end
    end
  end

  // Read-before-write: a same-edge write is merged by the caller.
  always_ff @(posedge clock) begin
    if (reset)       rdData_q <= '0;
    else if (rdEn_i) rdData_q <= mem_q[rdIdx_i];
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave with wait states, two-cycle ERROR and write-to-read forwarding.
// Define AHBL_SLV_ALIGN_CHK_EN to reject misaligned transfers with ERROR.
module ahb_lite_sram_slave
  import ahbl_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  reset,
  ahb_lite_sram_slave_if.slave bus
);

  localparam int         BPW      = DATA_WIDTH / 8;
  localparam int         SIZE_MAX = $clog2(BPW);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [32:0] RANGE   = 33'(DEPTH) * 33'(BPW);

  slvState_e             state_q;
  logic [3:0]            cnt_q;
  logic                  hreadyOut_q;
  logic                  hresp_q;
  logic                  wrPend_q;
  logic [IDX_W-1:0]      wrIdx_q;
  logic [BPW-1:0]        wrMask_q;
  logic [BPW-1:0]        fwdMask_q;
  logic [DATA_WIDTH-1:0] fwdData_q;

  logic [31:0]           offset;
  logic                  accept;
  logic                  illegal;
  logic [IDX_W-1:0]      reqIdx;
  logic [7:0]            laneAll;
  logic [BPW-1:0]        reqMask;
  logic                  commit;
  logic                  readAcc;
  logic                  fwdHit;
  logic [DATA_WIDTH-1:0] coreRdData;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  unusedBits;

  assign offset  = bus.HADDR - BASE_ADDR;
  assign accept  = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hreadyOut_q;
  assign reqIdx  = offset[SIZE_MAX +: IDX_W];
  assign laneAll = laneMask(bus.HSIZE, bus.HADDR[2:0] & 3'(BPW - 1));
  assign reqMask = laneAll[BPW-1:0];

`ifdef AHBL_SLV_ALIGN_CHK_EN
  logic [2:0] sizeLowMask;
  logic       misaligned;
  assign sizeLowMask = 3'((4'd1 << bus.HSIZE) - 4'd1);
  assign misaligned  = |(bus.HADDR[2:0] & sizeLowMask);
  assign illegal     = ({1'b0, offset} >= RANGE) | (bus.HSIZE > 3'(SIZE_MAX)) | misaligned;
`else
  assign illegal     = ({1'b0, offset} >= RANGE) | (bus.HSIZE > 3'(SIZE_MAX));
`endif

  // A write commits on the edge that ends its data phase; reset drops it.
  assign commit  = wrPend_q & hreadyOut_q & ~reset;
  assign readAcc = accept & ~illegal & ~bus.HWRITE;
  assign fwdHit  = commit & (wrIdx_q == reqIdx);

  ahbl_sram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_core (
    .clock   (HCLK),
    .reset   (reset),
    .we_i    (commit),
    .wrIdx_i (wrIdx_q),
    .wrMask_i(wrMask_q),
    .wrData_i(bus.HWDATA),
    .rdEn_i  (readAcc),
    .rdIdx_i (reqIdx),
    .rdData_o(coreRdData)
  );

  // Control FSM with registered HREADYOUT/HRESP plus the pending-write and
  // forwarding registers that travel with each accepted address phase.
  always_ff @(posedge HCLK) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hreadyOut_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      wrPend_q    <= 1'b0;
      wrIdx_q     <= '0;
      wrMask_q    <= '0;
      fwdMask_q   <= '0;
      fwdData_q   <= '0;
    end else begin
      if (readAcc) begin
        fwdMask_q <= fwdHit ? wrMask_q : '0;
        fwdData_q <= bus.HWDATA;
      end
      if (hreadyOut_q) wrPend_q <= accept & ~illegal & bus.HWRITE;
      if (accept) begin
        wrIdx_q  <= reqIdx;
        wrMask_q <= reqMask;
      end
      case (state_q)
        IDLE, ERR2: begin
          if (accept && illegal) begin
            state_q     <= ERR1;
            hreadyOut_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else if (accept && (WAIT_STATES > 0)) begin
            state_q     <= WAIT;
            cnt_q       <= 4'(WAIT_STATES - 1);
            hreadyOut_q <= 1'b0;
            hresp_q     <= HRESP_OKAY;
          end else begin
            state_q     <= IDLE;
            hreadyOut_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= IDLE;
            hreadyOut_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ERR1: begin
          state_q     <= ERR2;
          hreadyOut_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state_q     <= IDLE;
          hreadyOut_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Forwarded lanes overlay the stale word read from the array.
  always_comb begin
    hrdata = coreRdData;
    for (int b = 0; b < BPW; b++) begin
      if (fwdMask_q[b]) hrdata[8*b +: 8] = fwdData_q[8*b +: 8];
    end
  end

  assign bus.HRDATA    = hrdata;
  assign bus.HREADYOUT = hreadyOut_q;
  assign bus.HRESP     = hresp_q;

  assign unusedBits = ^{bus.HBURST, bus.HPROT, offset, laneAll, bus.HADDR};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench for ahb_lite_sram_slave: a zero-wait and a three-wait
// instance share one pipelined master and a byte-level memory model.
module tb_ahb_lite_sram_slave;
  import ahbl_pkg::*;

  typedef struct {
    bit          isData;
    bit          write;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          expErr;
    bit          expKnown;
    logic [31:0] expData;
    int          expWait;
  } txn_t;

  logic        HCLK = 1'b0;
  logic        reset;
  logic        useW3;
  logic        tbSel;
  logic [31:0] tbAddr;
  logic [1:0]  tbTrans;
  logic        tbWrite;
  logic [2:0]  tbSize;
  logic [31:0] tbWdata;
  logic        curReady;
  logic        curResp;
  logic [31:0] curRdata;

  int   errors = 0;
  int   checks = 0;
  txn_t seqQ[$];
  logic [7:0] modelMem [int];

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave_if #(.DATA_WIDTH(32)) bus0 ();
  ahb_lite_sram_slave_if #(.DATA_WIDTH(32)) bus3 ();

  assign bus0.HSEL   = tbSel & ~useW3;
  assign bus3.HSEL   = tbSel & useW3;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus3.HREADY = bus3.HREADYOUT;
  assign bus0.HADDR  = tbAddr;
  assign bus3.HADDR  = tbAddr;
  assign bus0.HTRANS = tbTrans;
  assign bus3.HTRANS = tbTrans;
  assign bus0.HWRITE = tbWrite;
  assign bus3.HWRITE = tbWrite;
  assign bus0.HSIZE  = tbSize;
  assign bus3.HSIZE  = tbSize;
  assign bus0.HBURST = 3'd0;
  assign bus3.HBURST = 3'd0;
  assign bus0.HPROT  = 4'b0011;
  assign bus3.HPROT  = 4'b0011;
  assign bus0.HWDATA = tbWdata;
  assign bus3.HWDATA = tbWdata;

  assign curReady = useW3 ? bus3.HREADYOUT : bus0.HREADYOUT;
  assign curResp  = useW3 ? bus3.HRESP     : bus0.HRESP;
  assign curRdata = useW3 ? bus3.HRDATA    : bus0.HRDATA;

  ahb_lite_sram_slave #(
    .DATA_WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) dut0 (
    .HCLK (HCLK),
    .reset(reset),
    .bus  (bus0)
  );

  ahb_lite_sram_slave #(
    .DATA_WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)
  ) dut3 (
    .HCLK (HCLK),
    .reset(reset),
    .bus  (bus3)
  );

  // Legality straight from the address map: 4 KiB window, at most word size.
  function automatic bit isIllegal(input logic [31:0] addr, input logic [2:0] size);
    bit bad;
    bad = (addr >= 32'h1000) || (size > 3'd2);
`ifdef AHBL_SLV_ALIGN_CHK_EN
    bad = bad || ((addr % (32'd1 << size)) != 0);
`endif
    return bad;
  endfunction

  // Queue a transfer and derive its expected response from the byte model.
  task automatic applyStimulus(input bit write, input logic [1:0] trans, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata);
    txn_t        t;
    int          key0;
    logic [31:0] aligned;
    logic [31:0] a;
    t.isData = trans[1];
    t.write = write;
    t.trans = trans;
    t.addr = addr;
    t.size = size;
    t.wdata = wdata;
    t.expErr = 1'b0;
    t.expKnown = 1'b0;
    t.expData = '0;
    t.expWait = 0;
    key0 = useW3 ? 8192 : 0;
    if (t.isData) begin
      t.expErr  = isIllegal(addr, size);
      t.expWait = t.expErr ? 1 : (useW3 ? 3 : 0);
      if (!t.expErr && write) begin
        aligned = addr & ~((32'd1 << size) - 32'd1);
        for (int i = 0; i < (1 << size); i++) begin
          a = aligned + 32'(i);
          modelMem[key0 + int'(a)] = wdata[8*a[1:0] +: 8];
        end
      end else if (!t.expErr) begin
        aligned = addr & ~32'd3;
        t.expKnown = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (modelMem.exists(key0 + int'(aligned) + i))
            t.expData[8*i +: 8] = modelMem[key0 + int'(aligned) + i];
          else
            t.expKnown = 1'b0;
        end
      end
    end
    seqQ.push_back(t);
  endtask

  task automatic driveAp(input bit valid, input txn_t t);
    if (valid) begin
      tbSel   = 1'b1;
      tbTrans = t.trans;
      tbAddr  = t.addr;
      tbWrite = t.write;
      tbSize  = t.size;
    end else begin
      tbSel   = 1'b0;
      tbTrans = HTRANS_IDLE;
      tbWrite = 1'b0;
    end
  endtask

  // Pipelined master: next address is presented while the previous data phase runs.
  task automatic checkOutput(input string name);
    txn_t ap, dp;
    bit   apV, dpV, prevReady, abort;
    int   lowCnt, guard;
    apV = 0; dpV = 0; abort = 0; lowCnt = 0; guard = 0;
    if (seqQ.size() > 0) begin ap = seqQ.pop_front(); apV = 1; end
    driveAp(apV, ap);
    prevReady = curReady;
    while ((apV || dpV) && !abort) begin
      @(posedge HCLK); #1;
      guard++;
      if (prevReady) begin
        dp = ap; dpV = apV; lowCnt = 0;
        tbWdata = (dpV && dp.write) ? dp.wdata : $urandom;
        apV = 0;
        if (seqQ.size() > 0) begin ap = seqQ.pop_front(); apV = 1; end
        driveAp(apV, ap);
      end
      if (dpV) begin
        if (!curReady) begin
          lowCnt++;
          checks++;
          if (curResp !== dp.expErr) begin
            errors++;
            $display("[TB] FAIL %s stall_resp addr=%h got=%b want=%b", name, dp.addr, curResp, dp.expErr);
          end
          if (lowCnt > 20) begin
            errors++;
            $display("[TB] FAIL %s timeout addr=%h low_cycles=%0d want=%0d", name, dp.addr, lowCnt, dp.expWait);
            abort = 1;
          end
        end else begin
          checks++;
          if (lowCnt !== dp.expWait) begin
            errors++;
            $display("[TB] FAIL %s wait_count addr=%h got=%0d want=%0d", name, dp.addr, lowCnt, dp.expWait);
          end
          checks++;
          if (curResp !== dp.expErr) begin
            errors++;
            $display("[TB] FAIL %s resp addr=%h got=%b want=%b", name, dp.addr, curResp, dp.expErr);
          end
          if (dp.isData && !dp.write && !dp.expErr && dp.expKnown) begin
            checks++;
            if (curRdata !== dp.expData) begin
              errors++;
              $display("[TB] FAIL %s rdata addr=%h got=%h want=%h", name, dp.addr, curRdata, dp.expData);
            end
          end
          dpV = 0;
        end
      end
      if (guard > 2000 && !abort) begin
        errors++;
        $display("[TB] FAIL %s stuck HREADYOUT=%b want=1", name, curReady);
        abort = 1;
      end
      prevReady = curReady;
    end
    if (abort) seqQ.delete();
    driveAp(0, ap);
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; useW3 = 1'b0;
    tbSel = 1'b1; tbTrans = HTRANS_NONSEQ; tbAddr = 32'h0; tbWrite = 1'b0; tbSize = 3'd2; tbWdata = '0;
    repeat (2) @(posedge HCLK);
    #1;
    checks += 6;
    if (bus0.HREADYOUT !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready0 got=%b want=1", bus0.HREADYOUT); end
    if (bus0.HRESP !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp0 got=%b want=0", bus0.HRESP); end
    if (bus0.HRDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata0 got=%h want=0", bus0.HRDATA); end
    if (bus3.HREADYOUT !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready3 got=%b want=1", bus3.HREADYOUT); end
    if (bus3.HRESP !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp3 got=%b want=0", bus3.HRESP); end
    if (bus3.HRDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata3 got=%h want=0", bus3.HRDATA); end
    reset = 1'b0;
    tbSel = 1'b0; tbTrans = HTRANS_IDLE;
    @(posedge HCLK); #1;
  endtask

  task automatic test_byte_lanes();
    useW3 = 1'b0;
    applyStimulus(1, HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 32'hDEADBEEF);
    applyStimulus(1, HTRANS_NONSEQ, 32'h2, HSIZE_HALF, 32'h1234_0000);
    applyStimulus(0, HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 32'h0);
    applyStimulus(1, HTRANS_NONSEQ, 32'h5, HSIZE_BYTE, 32'h0000_6600);
    applyStimulus(0, HTRANS_SEQ,    32'h4, HSIZE_BYTE, 32'h0);
    checkOutput("byte_lanes");
  endtask

  task automatic test_forwarding();
    useW3 = 1'b0;
    applyStimulus(1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'hA5A5A5A5);
    applyStimulus(0, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'h0);
    applyStimulus(1, HTRANS_NONSEQ, 32'h11, HSIZE_BYTE, 32'h0000_7700);
    applyStimulus(0, HTRANS_NONSEQ, 32'h10, HSIZE_BYTE, 32'h0);
    applyStimulus(0, HTRANS_IDLE,   32'h10, HSIZE_WORD, 32'h0);
    checkOutput("forwarding");
  endtask

  task automatic test_wait_states();
    useW3 = 1'b1;
    applyStimulus(1, HTRANS_NONSEQ, 32'h4, HSIZE_WORD, 32'h0BADF00D);
    applyStimulus(0, HTRANS_NONSEQ, 32'h4, HSIZE_WORD, 32'h0);
    applyStimulus(1, HTRANS_NONSEQ, 32'h8, HSIZE_WORD, 32'h13579BDF);
    applyStimulus(0, HTRANS_NONSEQ, 32'h8, HSIZE_WORD, 32'h0);
    applyStimulus(0, HTRANS_BUSY,   32'h8, HSIZE_WORD, 32'h0);
    checkOutput("wait_states");
  endtask

  task automatic test_out_of_range();
    useW3 = 1'b0;
    applyStimulus(0, HTRANS_NONSEQ, 32'h1000, HSIZE_WORD, 32'h0);
    applyStimulus(1, HTRANS_NONSEQ, 32'h1000, HSIZE_WORD, 32'hFFFFFFFF);
    applyStimulus(0, HTRANS_NONSEQ, 32'h0,    HSIZE_WORD, 32'h0);
    applyStimulus(1, HTRANS_NONSEQ, 32'hFFC,  HSIZE_WORD, 32'h600DCAFE);
    applyStimulus(0, HTRANS_NONSEQ, 32'hFFC,  HSIZE_WORD, 32'h0);
    applyStimulus(0, HTRANS_NONSEQ, 32'h8,    HSIZE_DWORD, 32'h0);
    checkOutput("out_of_range_w0");
    useW3 = 1'b1;
    applyStimulus(1, HTRANS_NONSEQ, 32'h2000, HSIZE_WORD, 32'hFFFFFFFF);
    applyStimulus(0, HTRANS_NONSEQ, 32'h4,    HSIZE_WORD, 32'h0);
    checkOutput("out_of_range_w3");
  endtask

  task automatic test_alignment();
    useW3 = 1'b0;
    applyStimulus(1, HTRANS_NONSEQ, 32'h3, HSIZE_WORD, 32'hCAFEF00D);
    applyStimulus(0, HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 32'h0);
    applyStimulus(1, HTRANS_NONSEQ, 32'h1, HSIZE_HALF, 32'h0000_4321);
    applyStimulus(0, HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 32'h0);
    checkOutput("alignment");
  endtask

  task automatic test_back_to_back();
    int          r;
    logic [31:0] addr;
    logic [2:0]  size;
    for (int d = 0; d < 2; d++) begin
      useW3 = (d == 1);
      for (int i = 0; i < 16; i++) applyStimulus(1, HTRANS_NONSEQ, 32'(i * 4), HSIZE_WORD, $urandom);
      checkOutput("fill");
      for (int n = 0; n < 60; n++) begin
        r = int'($urandom_range(0, 99));
        if (r < 8) begin
          applyStimulus(0, (r < 4) ? HTRANS_IDLE : HTRANS_BUSY, 32'h0, HSIZE_WORD, 32'h0);
        end else begin
          addr = (r < 14) ? (32'h1000 + $urandom_range(0, 255)) : 32'($urandom_range(0, 63));
          size = (r < 18) ? HSIZE_DWORD : 3'($urandom_range(0, 2));
          applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ,
                        addr, size, $urandom);
        end
      end
      checkOutput("back_to_back");
    end
  endtask

  task automatic test_reset_mid();
    useW3 = 1'b1;
    applyStimulus(1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 32'h11111111);
    checkOutput("reset_mid_setup");
    tbSel = 1'b1; tbTrans = HTRANS_NONSEQ; tbAddr = 32'h20; tbWrite = 1'b1; tbSize = HSIZE_WORD;
    @(posedge HCLK); #1;
    checks++;
    if (curReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_wait got=%b want=0", curReady); end
    tbWdata = 32'h22222222;
    reset = 1'b1;
    @(posedge HCLK); #1;
    checks += 3;
    if (curReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_ready got=%b want=1", curReady); end
    if (curResp !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_resp got=%b want=0", curResp); end
    if (curRdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid_rdata got=%h want=0", curRdata); end
    reset = 1'b0;
    tbSel = 1'b0; tbTrans = HTRANS_IDLE; tbWrite = 1'b0;
    @(posedge HCLK); #1;
    applyStimulus(0, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 32'h0);
    checkOutput("reset_mid_discard");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got=running want=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_byte_lanes();
    test_forwarding();
    test_wait_states();
    test_out_of_range();
    test_alignment();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
